// File: rtl/var_delay_line.sv
// var_delay_line: run-time programmable delay line for a DATA_W-bit stream
// with a valid qualifier. A fixed-depth shift register always holds the last
// MAX_DELAY input slots. A combinational tap mux picks the slot matching the
// clamped, registered delay. When the delay changes, a settle counter masks
// the output valid for D_new cycles so that downstream logic never sees a
// sample taken across the delay change.
module var_delay_line #(
  parameter int DATA_W    = 8,
  parameter int MAX_DELAY = 15,
  parameter int DELAY_W   = $clog2(MAX_DELAY + 1)
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               data_val_i,
  input  logic [DELAY_W-1:0] delay_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               data_val_o,
  output logic               settle_o
);

  localparam logic [DELAY_W-1:0] D_MIN = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] D_MAX = DELAY_W'(MAX_DELAY);

  // Saturate a requested delay into the range of taps that physically exist.
  // Zero maps to one because the registered path has one cycle of latency.
  function automatic logic [DELAY_W-1:0] clamp_delay(input logic [DELAY_W-1:0] d);
    if (d == '0) begin
      return D_MIN;
    end else if (d > D_MAX) begin
      return D_MAX;
    end else begin
      return d;
    end
  endfunction

  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] settle_cnt;
  logic [DELAY_W-1:0] tap_sel;

  logic [DATA_W-1:0]    data_sr [MAX_DELAY];
  logic [MAX_DELAY-1:0] vld_sr;

  logic [DATA_W-1:0] tap_data;
  logic              tap_vld;

  // Delay register and settle counter. A change reloads the counter from the
  // newest clamped delay. An unchanged delay only lets the counter run down.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      delay_q    <= '0;
      settle_cnt <= '0;
    end else if (delay_i != delay_q) begin
      delay_q    <= delay_i;
      settle_cnt <= clamp_delay(delay_i);
    end else if (settle_cnt != '0) begin
      settle_cnt <= settle_cnt - D_MIN;
    end
  end

  // Sample storage: shifts every cycle, including invalid slots, so that
  // valid gaps reach the output unchanged. Reset flushes in-flight samples.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      for (int k = 0; k < MAX_DELAY; k++) begin
        data_sr[k] <= '0;
        vld_sr[k]  <= 1'b0;
      end
    end else begin
      data_sr[0] <= data_i;
      vld_sr[0]  <= data_val_i;
      for (int k = 1; k < MAX_DELAY; k++) begin
        data_sr[k] <= data_sr[k-1];
        vld_sr[k]  <= vld_sr[k-1];
      end
    end
  end

  // Output stage boundary: the tap index comes from delay_q only, so the
  // mux is driven purely from flops (no data_i -> data_o path).
  assign tap_sel = clamp_delay(delay_q) - D_MIN;

  // Tap mux: select the slot that holds the sample taken D cycles ago.
  always_comb begin
    tap_data = '0;
    tap_vld  = 1'b0;
    for (int k = 0; k < MAX_DELAY; k++) begin
      if (tap_sel == DELAY_W'(k)) begin
        tap_data = data_sr[k];
        tap_vld  = vld_sr[k];
      end
    end
  end

  assign settle_o   = (settle_cnt != '0);
  assign data_o     = tap_data;
  assign data_val_o = tap_vld & ~settle_o;

endmodule
